sram_master_ctrl: RTL and testbench

//  Clocked initiator that drives the cs/oe/we/addr/din/dout asynchronous SRAM port on behalf of the

---
 rtl/sram_master_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_sram_master_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_master_ctrl.sv
// sram_master_ctrl: single-outstanding initiator for an asynchronous SRAM
// port (cs/oe/we/addr/din/dout). A request is latched in IDLE and then
// sequenced through setup, strobe and hold phases. One down-counter times
// all three phases, and a phase with zero length is skipped. Read data or
// write completion is returned over a valid/ready response channel.
//
// Optional build macro: SRAM_MASTER_ALIGN_CHECK_EN
//   When defined, a request whose address is not word aligned is accepted
//   but never reaches the SRAM. It is answered on the next cycle with
//   rsp_err=1. When undefined, all addresses pass through and rsp_err is 0.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; SRAM deselected, addr/din forced to 0
// SETUP  | cs + addr (+din) stable ahead of the strobe
// ACCESS | oe (read) or we (write) asserted; read data captured on last edge
// HOLD   | strobe dropped, cs + addr (+din) still held
// RESP   | rsp_valid held until rsp_ready; SRAM deselected

module sram_master_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  // The counter only ever holds a phase length minus one.
  localparam int MAX_CYC_SA = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_CYC    = (MAX_CYC_SA > HOLD_CYC) ? MAX_CYC_SA : HOLD_CYC;
  localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC  > 0) ? SETUP_CYC  - 1 : 0);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'((ACCESS_CYC > 0) ? ACCESS_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC   > 0) ? HOLD_CYC   - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misalign;
  logic              busy;
  logic              cnt_zero;

`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  assign misalign = (req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign cnt_zero = (cnt_q == '0);

  // State, phase timer and latched request/response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state sequencing: accept, phase timing, read capture, response handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (misalign) begin
            // Rejected requests never touch the SRAM.
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (SETUP_CYC > 0) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = ACCESS_LD;
          end
        end
      end

      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_ACCESS: begin
        if (cnt_zero) begin
          // oe is still asserted during this cycle, so dout is valid at the edge.
          if (!we_q) begin
            rdata_d = sram_dout;
          end
          if (HOLD_CYC > 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
          rdata_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of registered state; nothing depends on req_* directly.
  assign busy      = (state_q == ST_SETUP) || (state_q == ST_ACCESS) || (state_q == ST_HOLD);
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign sram_cs   = busy;
  assign sram_oe   = (state_q == ST_ACCESS) && !we_q;
  assign sram_we   = (state_q == ST_ACCESS) && we_q;
  assign sram_addr = busy ? addr_q : '0;
  assign sram_din  = (busy && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_sram_master_ctrl.sv
// Bench for sram_master_ctrl: two instances (default timing and the
// zero-setup/zero-hold/one-access variant), each with its own behavioural
// SRAM. A table of directed transactions runs first, then reset during
// ACCESS, then randomized traffic checked against a word-indexed memory model.
module tb_sram_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [1:0] req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [1:0] cs, oe, we;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata, s_addr, s_din, s_dout;
  logic [31:0] mem [2][256];
  logic [31:0] ref_mem [2][256];

  int checks = 0;
  int errors = 0;

`ifdef SRAM_MASTER_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  sram_master_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]),
    .sram_cs(cs[0]), .sram_oe(oe[0]), .sram_we(we[0]),
    .sram_addr(s_addr[0]), .sram_din(s_din[0]), .sram_dout(s_dout[0])
  );

  sram_master_ctrl #(.SETUP_CYC(0), .ACCESS_CYC(1), .HOLD_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]),
    .sram_cs(cs[1]), .sram_oe(oe[1]), .sram_we(we[1]),
    .sram_addr(s_addr[1]), .sram_din(s_din[1]), .sram_dout(s_dout[1])
  );

  // Behavioural SRAMs: read data only while selected and output-enabled.
  for (genvar g = 0; g < 2; g++) begin : g_sram
    assign s_dout[g] = (cs[g] && oe[g]) ? mem[g][s_addr[g][9:2]] : 32'hBAD0_BAD0;
    initial begin
      for (int i = 0; i < 256; i++) mem[g][i] = '0;
      forever begin
        @(posedge clk);
        if (cs[g] && we[g]) mem[g][s_addr[g][9:2]] = s_din[g];
      end
    end
  end

  function automatic int setup_of(input int d);  return (d == 0) ? 1 : 0; endfunction
  function automatic int access_of(input int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int hold_of(input int d);   return (d == 0) ? 1 : 0; endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction on instance d, starting and ending at a falling edge.
  task automatic do_txn(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input int wt, output logic [31:0] got);
    bit err, ecs, eac;
    int s, ac, h, lat, n, bad_cyc, unstable;
    int idx;
    logic [31:0] exp_rd;
    err = ALIGN && (a[1:0] != 2'b00);
    s = err ? 0 : setup_of(d);
    ac = err ? 0 : access_of(d);
    h = err ? 0 : hold_of(d);
    lat = 1 + s + ac + h;
    idx = int'((a >> 2) & 32'd255);
    exp_rd = (w || err) ? 32'h0 : ref_mem[d][idx];
    if (w && !err) ref_mem[d][idx] = wd;

    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_ready_before_accept_d%0d", d), 32'(req_ready[d]), 32'h1);

    req_valid[d] = 1'b1; req_we[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;

    bad_cyc = 0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      ecs = (k <= s + ac + h);
      eac = (k > s) && (k <= s + ac);
      if (bad_cyc == 0 &&
          (cs[d] !== ecs || oe[d] !== (eac && !w) || we[d] !== (eac && w) ||
           s_addr[d] !== (ecs ? a : 32'h0) || s_din[d] !== ((ecs && w) ? wd : 32'h0) ||
           rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0))
        bad_cyc = k;
    end
    chk($sformatf("wave_first_bad_cycle_d%0d_a%h", d, a), 32'(bad_cyc), 32'h0);

    @(negedge clk);
    chk($sformatf("rsp_valid_at_latency_d%0d", d), 32'(rsp_valid[d]), 32'h1);
    chk($sformatf("rsp_rdata_d%0d_a%h", d, a), rsp_rdata[d], exp_rd);
    chk($sformatf("rsp_err_d%0d_a%h", d, a), 32'(rsp_err[d]), 32'(err));
    chk($sformatf("resp_sram_quiet_d%0d", d),
        {27'h0, cs[d], oe[d], we[d], |s_addr[d], |s_din[d]}, 32'h0);
    got = rsp_rdata[d];

    unstable = 0;
    if (wt > 0) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = 32'h0000_1010;
      for (int i = 0; i < wt; i++) begin
        @(negedge clk);
        if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp_rd || req_ready[d] !== 1'b0 ||
            cs[d] !== 1'b0)
          unstable++;
      end
      chk($sformatf("backpressure_unstable_cycles_d%0d", d), 32'(unstable), 32'h0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("post_handshake_vrer_d%0d", d),
        {28'h0, rsp_valid[d], req_ready[d], rsp_err[d], |rsp_rdata[d]}, 32'h4);
  endtask

  typedef struct {
    int          d;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    int          wt;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] got;
    int bad;
    rst_n = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = '0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;

    vecs[0] = '{0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0};
    vecs[1] = '{0, 1'b0, 32'h0000_1000, 32'h0,         3, 32'hDEAD_BEEF};
    vecs[2] = '{0, 1'b1, 32'h0000_1004, 32'h1234_5678, 1, 32'h0};
    vecs[3] = '{0, 1'b0, 32'h0000_1004, 32'h0,         0, 32'h1234_5678};
    vecs[4] = '{0, 1'b0, 32'h0000_2010, 32'h0,         0, 32'h0};
    vecs[5] = '{0, 1'b1, 32'h0000_1002, 32'hCAFE_F00D, 0, 32'h0};
    vecs[6] = '{0, 1'b0, 32'h0000_1000, 32'h0,         0,
                ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D};
    vecs[7] = '{1, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 0, 32'h0};
    vecs[8] = '{1, 1'b0, 32'h0000_0004, 32'h0,         2, 32'hA5A5_A5A5};

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ctrl_d%0d", d),
          {26'h0, req_ready[d], rsp_valid[d], rsp_err[d], cs[d], oe[d], we[d]}, 32'h20);
      chk($sformatf("reset_data_d%0d", d),
          {29'h0, |s_addr[d], |s_din[d], |rsp_rdata[d]}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].wt, got);
      chk($sformatf("table_rdata_%0d", i), got, vecs[i].exp_rd);
    end

    // Reset asserted during the first ACCESS cycle of a write. The data written
    // equals what the model already holds, so a partial update is harmless.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h0000_1008;
    req_wdata[0] = ref_mem[0][2];
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_test_we_in_access", 32'(we[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_access_outputs",
        {27'h0, cs[0], we[0], oe[0], rsp_valid[0], req_ready[0]}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || cs[0] !== 1'b0) bad++;
    end
    chk("after_reset_idle_no_rsp", 32'(bad), 32'h0);

    for (int i = 0; i < 60; i++) begin
      int d, wt;
      bit w;
      logic [31:0] a, wd;
      d  = $urandom_range(0, 1);
      w  = 1'($urandom_range(0, 1));
      a  = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wd = $urandom;
      wt = $urandom_range(0, 3);
      do_txn(d, w, a, wd, wt, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
